// File: rtl/wbs_host_pkg.sv
// Shared types for the Wishbone host master: command record, FSM states
// and the default error word returned on a timed-out transfer.
package wbs_host_pkg;

  // Read data reported when a transfer is abandoned after a timeout.
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // One queued bus command, 69 bits.
  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wbm_cmd_t;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } wbm_state_e;

endpackage

// File: rtl/wbs_host_cmd_fifo.sv
// Command queue for the Wishbone host master. Pointers carry one extra
// bit so full and empty are told apart by the MSB alone; a simultaneous
// push and pop leaves the occupancy unchanged.
module wbs_host_cmd_fifo
  import wbs_host_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     i_clk,
  input  logic     i_rst,
  input  logic     i_push,
  input  wbm_cmd_t i_data,
  input  logic     i_pop,
  output wbm_cmd_t o_data,
  output logic     o_full,
  output logic     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  wbm_cmd_t    r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  // Pushes into a full queue and pops from an empty one are dropped.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers; reset flushes the queue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Store the incoming command at the write slot.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/wbs_host_master.sv
// Wishbone classic single-transfer master. Commands are queued over a
// valid/ready port, each one becomes exactly one bus cycle, and each
// bus cycle yields exactly one held response, in order.
// Optional feature macro: WBS_HOST_MASTER_TIMEOUT_EN -- abandons a bus
// cycle that is not acknowledged within TIMEOUT_CYC wait cycles and
// reports ERR_DATA with rsp_err set. Without it REQ waits forever.
module wbs_host_master
  import wbs_host_pkg::*;
#(
  parameter int          CMD_DEPTH   = 4,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
  output logic        busy
);

  wbm_cmd_t    w_cmd_in;
  wbm_cmd_t    w_head;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_push;
  logic        w_pop;

  wbm_state_e  r_state;
  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_adr;
  logic [31:0] r_dat;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_dat;

`ifdef WBS_HOST_MASTER_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] r_to_cnt;
  logic            r_rsp_err;

  assign rsp_err = r_rsp_err;
`else
  // Timeout configuration has no effect in this build.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{TIMEOUT_CYC, ERR_DATA};
  assign rsp_err      = 1'b0;
`endif

  assign w_cmd_in = '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
  assign w_push   = cmd_valid && !w_fifo_full;
  // The head leaves the queue on the same edge that launches its bus cycle.
  assign w_pop    = (r_state == IDLE) && !w_fifo_empty;

  wbs_host_cmd_fifo #(
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (w_push),
    .i_data  (w_cmd_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign cmd_ready = !w_fifo_full;
  assign busy      = !w_fifo_empty || (r_state != IDLE);

  // Classic Wishbone: strobe is asserted for the whole cycle.
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign wbm_we_o  = r_we;
  assign wbm_sel_o = r_sel;
  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = r_dat;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;

  // Transfer sequencer: launch from the queue, wait for ack, hold response.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_adr       <= 32'h0;
      r_dat       <= 32'h0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= 32'h0;
`ifdef WBS_HOST_MASTER_TIMEOUT_EN
      r_to_cnt    <= '0;
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_fifo_empty) begin
            r_cyc   <= 1'b1;
            r_we    <= w_head.we;
            r_sel   <= w_head.sel;
            r_adr   <= w_head.adr;
            r_dat   <= w_head.dat;
            r_state <= REQ;
`ifdef WBS_HOST_MASTER_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
          end
        end
        REQ: begin
          // An ack on the final timeout edge still completes normally.
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_rsp_dat   <= r_we ? 32'h0 : wbm_dat_i;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
`ifdef WBS_HOST_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_to_cnt == TO_LAST) begin
            r_cyc       <= 1'b0;
            r_rsp_dat   <= ERR_DATA;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end else begin
            r_to_cnt    <= r_to_cnt + TO_ONE;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wbs_host_master.sv
// Directed self-checking bench for wbs_host_master. The bench plays the
// Wishbone slave itself, driving ack/read data on the falling edge.
`timescale 1ns/1ps
module tb_wbs_host_master;

  localparam int TB_DEPTH   = 4;
  localparam int TB_TIMEOUT = 8;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  wbs_host_master #(
    .CMD_DEPTH   (TB_DEPTH),
    .TIMEOUT_CYC (TB_TIMEOUT),
    .ERR_DATA    (32'hDEAD_BEEF)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .busy      (busy)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Offer one command and hold it until accepted (bounded).
  task automatic push_cmd(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          output bit ok);
    @(negedge wb_clk_i);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    ok        = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge wb_clk_i);
    end
    @(posedge wb_clk_i);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Advance falling edges until a bus cycle is open (bounded).
  task automatic wait_cyc(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk_i);
      if (wbm_cyc_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Acknowledge for exactly one rising edge; returns on the next falling edge.
  task automatic ack_with(input logic [31:0] dat);
    wbm_ack_i = 1'b1;
    wbm_dat_i = dat;
    @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge wb_clk_i);
    n_tests++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || wbm_we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_bus: cyc/stb/we got %b%b%b expected 000", wbm_cyc_o, wbm_stb_o, wbm_we_o);
    end
    n_tests++;
    if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || wbm_sel_o !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_fields: adr %h dat %h sel %h expected zeros", wbm_adr_o, wbm_dat_o, wbm_sel_o);
    end
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready_busy: ready %b busy %b expected 1 0", cmd_ready, busy);
    end
    n_tests++;
    if (rsp_valid !== 1'b0 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: valid %b dat %h err %b expected 0 0 0", rsp_valid, rsp_dat, rsp_err);
    end
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    n_tests++;
    if (wbm_cyc_o !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_idle: cyc %b busy %b ready %b expected 0 0 1", wbm_cyc_o, busy, cmd_ready);
    end
  endtask

  task automatic test_write_read();
    bit ok;
    push_cmd(1'b1, 32'h3000_0004, 32'h0000_0001, 4'hF, ok);
    n_tests++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL wr_accept: got %b expected 1", ok); end
    @(negedge wb_clk_i);
    n_tests++;
    if (wbm_cyc_o !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_latency_early: cyc %b busy %b expected 0 1", wbm_cyc_o, busy);
    end
    @(negedge wb_clk_i);
    n_tests++;
    if (wbm_cyc_o !== 1'b1 || wbm_stb_o !== 1'b1 || wbm_we_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_launch: cyc/stb/we %b%b%b expected 111", wbm_cyc_o, wbm_stb_o, wbm_we_o);
    end
    n_tests++;
    if (wbm_adr_o !== 32'h3000_0004 || wbm_dat_o !== 32'h0000_0001 || wbm_sel_o !== 4'hF) begin
      n_fail++;
      $display("FAIL wr_fields: adr %h dat %h sel %h expected 30000004 00000001 f", wbm_adr_o, wbm_dat_o, wbm_sel_o);
    end
    @(negedge wb_clk_i);
    ack_with(32'h1234_5678);
    n_tests++;
    if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_rsp: cyc %b valid %b dat %h err %b expected 0 1 0 0", wbm_cyc_o, rsp_valid, rsp_dat, rsp_err);
    end
    n_tests++;
    if (wbm_we_o !== 1'b1 || wbm_dat_o !== 32'h1 || wbm_sel_o !== 4'hF) begin
      n_fail++;
      $display("FAIL wr_hold_after: we %b dat %h sel %h expected 1 00000001 f", wbm_we_o, wbm_dat_o, wbm_sel_o);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_consume: valid %b expected 0", rsp_valid); end

    push_cmd(1'b0, 32'h3000_0004, 32'h0000_0000, 4'hF, ok);
    wait_cyc(ok);
    n_tests++;
    if (ok !== 1'b1 || wbm_we_o !== 1'b0 || wbm_adr_o !== 32'h3000_0004) begin
      n_fail++;
      $display("FAIL rd_launch: ok %b we %b adr %h expected 1 0 30000004", ok, wbm_we_o, wbm_adr_o);
    end
    @(negedge wb_clk_i);
    ack_with(32'h0000_0001);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0000_0001 || rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_rsp: valid %b dat %h err %b expected 1 00000001 0", rsp_valid, rsp_dat, rsp_err);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    bit ok;
    bit all_ok;
    all_ok = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_cmd(1'b0, 32'h0000_0100 + 32'(k * 4), 32'h0, 4'h3, ok);
      all_ok = all_ok & ok;
    end
    n_tests++;
    if (all_ok !== 1'b1) begin n_fail++; $display("FAIL full_accept5: got %b expected 1", all_ok); end
    @(negedge wb_clk_i);
    n_tests++;
    if (cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL full_ready: ready %b cyc %b adr %h expected 0 1 00000100", cmd_ready, wbm_cyc_o, wbm_adr_o);
    end
    // A sixth command offered while full must not be taken.
    cmd_valid = 1'b1;
    cmd_adr   = 32'h0000_0200;
    repeat (3) @(negedge wb_clk_i);
    n_tests++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_stall: ready %b expected 0", cmd_ready); end
    cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_cyc(ok);
      n_tests++;
      if (ok !== 1'b1 || wbm_adr_o !== 32'h0000_0100 + 32'(k * 4)) begin
        n_fail++;
        $display("FAIL full_order: k %0d ok %b adr %h expected %h", k, ok, wbm_adr_o, 32'h100 + 32'(k * 4));
      end
      if (k == 1) begin
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back: ready %b expected 1", cmd_ready); end
      end
      ack_with(32'h0000_00A0 + 32'(k));
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0000_00A0 + 32'(k)) begin
        n_fail++;
        $display("FAIL full_rsp: k %0d valid %b dat %h expected 1 %h", k, rsp_valid, rsp_dat, 32'hA0 + 32'(k));
      end
    end
    repeat (4) @(negedge wb_clk_i);
    n_tests++;
    if (busy !== 1'b0 || wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: busy %b cyc %b valid %b expected 0 0 0", busy, wbm_cyc_o, rsp_valid);
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    rsp_ready = 1'b0;
    push_cmd(1'b0, 32'h0000_0040, 32'h0, 4'hF, ok);
    push_cmd(1'b0, 32'h0000_0044, 32'h0, 4'hF, ok);
    wait_cyc(ok);
    n_tests++;
    if (ok !== 1'b1 || wbm_adr_o !== 32'h40) begin
      n_fail++;
      $display("FAIL bp_launch: ok %b adr %h expected 1 00000040", ok, wbm_adr_o);
    end
    ack_with(32'h5555_AAAA);
    for (int c = 0; c < 10; c++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || rsp_dat !== 32'h5555_AAAA || wbm_cyc_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d valid %b dat %h cyc %b expected 1 5555aaaa 0", c, rsp_valid, rsp_dat, wbm_cyc_o);
      end
      @(negedge wb_clk_i);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: valid %b cyc %b expected 0 0", rsp_valid, wbm_cyc_o);
    end
    wait_cyc(ok);
    n_tests++;
    if (ok !== 1'b1 || wbm_adr_o !== 32'h44) begin
      n_fail++;
      $display("FAIL bp_second: ok %b adr %h expected 1 00000044", ok, wbm_adr_o);
    end
    ack_with(32'h0F0F_0F0F);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_dat !== 32'h0F0F_0F0F) begin
      n_fail++;
      $display("FAIL bp_second_rsp: valid %b dat %h expected 1 0f0f0f0f", rsp_valid, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    push_cmd(1'b0, 32'h0000_0080, 32'h0, 4'hF, ok);
    push_cmd(1'b0, 32'h0000_0084, 32'h0, 4'hF, ok);
    wait_cyc(ok);
    #2;
    wb_rst_i = 1'b1;
    #1;
    n_tests++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_bus: cyc %b stb %b expected 0 0", wbm_cyc_o, wbm_stb_o);
    end
    n_tests++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_state: busy %b ready %b valid %b expected 0 1 0", busy, cmd_ready, rsp_valid);
    end
    @(negedge wb_clk_i);
    wb_rst_i  = 1'b0;
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'hCAFE_0000;
    repeat (2) @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL arst_quiet: cycle %0d valid %b cyc %b busy %b expected 0 0 0", c, rsp_valid, wbm_cyc_o, busy);
      end
      @(negedge wb_clk_i);
    end
  endtask

`ifdef WBS_HOST_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    rsp_ready = 1'b0;
    push_cmd(1'b0, 32'h0000_0500, 32'h0, 4'hF, ok);
    wait_cyc(ok);
    for (int c = 1; c <= TB_TIMEOUT; c++) begin
      @(negedge wb_clk_i);
      n_tests++;
      if (wbm_cyc_o !== 1'b1) begin
        n_fail++;
        $display("FAIL to_wait: wait %0d cyc %b expected 1", c, wbm_cyc_o);
      end
    end
    @(negedge wb_clk_i);
    n_tests++;
    if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL to_abort: cyc %b valid %b err %b dat %h expected 0 1 1 deadbeef", wbm_cyc_o, rsp_valid, rsp_err, rsp_dat);
    end
    wbm_ack_i = 1'b1;
    wbm_dat_i = 32'h7777_7777;
    repeat (2) @(negedge wb_clk_i);
    wbm_ack_i = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'hDEAD_BEEF || wbm_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_late_ack: valid %b err %b dat %h cyc %b expected 1 1 deadbeef 0", rsp_valid, rsp_err, rsp_dat, wbm_cyc_o);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_done: valid %b busy %b expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_timeout_boundary();
    bit ok;
    push_cmd(1'b0, 32'h0000_0600, 32'h0, 4'hF, ok);
    wait_cyc(ok);
    repeat (TB_TIMEOUT) @(negedge wb_clk_i);
    ack_with(32'h0BAD_F00D);
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL to_boundary: valid %b err %b dat %h expected 1 0 0badf00d", rsp_valid, rsp_err, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge wb_clk_i);
    rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h0;
    cmd_dat   = 32'h0;
    cmd_sel   = 4'h0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    repeat (2) @(negedge wb_clk_i);
    test_reset();
    test_write_read();
    test_fifo_full();
    test_backpressure();
    test_async_reset();
`ifdef WBS_HOST_MASTER_TIMEOUT_EN
    test_timeout();
    test_timeout_boundary();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case a wait above never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000 ns, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
